// File: rtl/time_disp_pkg.sv
// Shared constants for the BCD time word and the 7-segment display path.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package time_disp_pkg;

  localparam int unsigned TIME_W = 20;

  // Field positions within the packed BCD time word (shared with the counter)
  localparam int unsigned SEC_L_LSB = 0;
  localparam int unsigned SEC_L_W   = 4;
  localparam int unsigned SEC_H_LSB = 4;
  localparam int unsigned SEC_H_W   = 3;
  localparam int unsigned MIN_L_LSB = 7;
  localparam int unsigned MIN_L_W   = 4;
  localparam int unsigned MIN_H_LSB = 11;
  localparam int unsigned MIN_H_W   = 3;
  localparam int unsigned HOU_L_LSB = 14;
  localparam int unsigned HOU_L_W   = 4;
  localparam int unsigned HOU_H_LSB = 18;
  localparam int unsigned HOU_H_W   = 2;

  localparam logic [2:0] DIG_SEC_L = 3'd0;
  localparam logic [2:0] DIG_SEC_H = 3'd1;
  localparam logic [2:0] DIG_MIN_L = 3'd2;
  localparam logic [2:0] DIG_MIN_H = 3'd3;
  localparam logic [2:0] DIG_HOU_L = 3'd4;
  localparam logic [2:0] DIG_HOU_H = 3'd5;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Select one digit of the time word, zero-extending the narrow fields
  function automatic logic [3:0] field_digit(input logic [TIME_W-1:0] t, input logic [2:0] idx);
    logic [3:0] d;
    d = 4'd0;
    unique case (idx)
      DIG_SEC_L: d = t[SEC_L_LSB +: SEC_L_W];
      DIG_SEC_H: d = {1'b0, t[SEC_H_LSB +: SEC_H_W]};
      DIG_MIN_L: d = t[MIN_L_LSB +: MIN_L_W];
      DIG_MIN_H: d = {1'b0, t[MIN_H_LSB +: MIN_H_W]};
      DIG_HOU_L: d = t[HOU_L_LSB +: HOU_L_W];
      DIG_HOU_H: d = {2'b00, t[HOU_H_LSB +: HOU_H_W]};
      default:   d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; values above 9 show a dash.
module bcd_to_seg7 (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  import time_disp_pkg::*;

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the packed BCD hh.mm.ss time word.
// The time word is captured once per frame so a frame never mixes two times.
module time_display_scan #(
  parameter int unsigned SLOT_CYC    = 8333,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic [19:0] time_in,
  input  logic        blank_lead,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel
);
  import time_disp_pkg::*;

  localparam int unsigned CntW   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [6:0]  SegInv = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic        DpInv  = SEG_ACT_LOW;
  localparam logic [5:0]  DigInv = DIG_ACT_LOW ? 6'h3F : 6'h00;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [TIME_W-1:0] snap_q, snap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [5:0]        dig_q, dig_d;

  logic              tick;
  logic [3:0]        digit;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_raw;
  logic              dp_raw;
  logic [5:0]        dig_raw;

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    tick   = (cnt_q == CntW'(SLOT_CYC - 1));
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (tick) begin
      idx_d = (idx_q == DIG_HOU_H) ? DIG_SEC_L : idx_q + 3'd1;
      if (idx_q == DIG_HOU_H) begin
        snap_d = time_in;
      end
    end

    digit   = field_digit(snap_q, idx_q);
    seg_raw = dec_seg;
    if (blank_lead && (idx_q == DIG_HOU_H) && (snap_q[HOU_H_LSB +: HOU_H_W] == 2'b00)) begin
      seg_raw = SEG_OFF;
    end
    // Colon dots between hh.mm.ss, blinking with the seconds LSB
    dp_raw = ((idx_q == DIG_MIN_L) || (idx_q == DIG_HOU_L)) && !snap_q[SEC_L_LSB];

    // Select is dropped on the slot's last cycle as well, so the dark gap before
    // the next digit covers BLANK_CYC+1 cycles of the registered output.
    dig_raw = '0;
    if ((cnt_q >= CntW'(BLANK_CYC)) && !tick) begin
      dig_raw = 6'b000001 << idx_q;
    end

    seg_d = seg_raw ^ SegInv;
    dp_d  = dp_raw ^ DpInv;
    dig_d = dig_raw ^ DigInv;
  end

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      idx_q  <= DIG_SEC_L;
      snap_q <= '0;
      seg_q  <= SegInv;
      dp_q   <= DpInv;
      dig_q  <= DigInv;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan: per-slot expectations are queued when a
// frame's time word is chosen and popped as each digit's select pulse ends.
module tb_time_display_scan;

  localparam int unsigned SLOT_CYC  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          ON_CYC    = SLOT_CYC - BLANK_CYC - 1;

  typedef struct packed {
    logic [5:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk_sys;
  logic        rstn;
  logic [19:0] time_in;
  logic        blank_lead;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;

  int   checks;
  int   fails;
  int   obs_cnt;
  exp_t exp_q[$];

  time_display_scan #(
    .SLOT_CYC    (SLOT_CYC),
    .BLANK_CYC   (BLANK_CYC),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk_sys    (clk_sys),
    .rstn       (rstn),
    .time_in    (time_in),
    .blank_lead (blank_lead),
    .seg        (seg),
    .dp         (dp),
    .dig_sel    (dig_sel)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] seg7_model(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [3:0] digit_model(input logic [19:0] t, input int d);
    case (d)
      0: return t[3:0];
      1: return {1'b0, t[6:4]};
      2: return t[10:7];
      3: return {1'b0, t[13:11]};
      4: return t[17:14];
      default: return {2'b00, t[19:18]};
    endcase
  endfunction

  // Queue the six slots a frame showing time word t should produce (active-low)
  task automatic push_frame(input logic [19:0] t, input logic bl);
    exp_t e;
    logic [6:0] seg_h;
    for (int d = 0; d < 6; d++) begin
      seg_h = seg7_model(digit_model(t, d));
      if (d == 5 && bl && t[19:18] == 2'b00) seg_h = 7'h00;
      e.dig = ~(6'b000001 << d);
      e.seg = ~seg_h;
      e.dp  = ((d == 2 || d == 4) && !t[0]) ? 1'b0 : 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_obs(input int n);
    int target;
    int budget;
    target = obs_cnt + n;
    budget = 0;
    while (obs_cnt < target && budget < 400) begin
      @(negedge clk_sys);
      #1;
      budget++;
    end
    if (obs_cnt < target) begin
      checks++;
      fails++;
      $error("FAIL wait_obs_timeout observed=%0d expected=%0d", obs_cnt, target);
    end
  endtask

  // Called at the start of a frame: t_show is what this frame displays,
  // t_next is driven now and captured at the end of this frame.
  task automatic do_frame(input logic [19:0] t_show, input logic bl, input logic [19:0] t_next,
                          input logic mid_en, input logic [19:0] t_mid);
    blank_lead = bl;
    time_in    = t_next;
    push_frame(t_show, bl);
    if (mid_en) begin
      wait_obs(2);
      time_in = t_mid;
      wait_obs(4);
    end else begin
      wait_obs(6);
    end
  endtask

  // Monitor: one observation per digit select pulse
  int         run_len;
  logic [5:0] run_dig;
  logic [6:0] run_seg;
  logic       run_dp;
  logic       run_stable;
  exp_t       exp_e;

  always @(negedge clk_sys) begin
    if (!rstn) begin
      run_len = 0;
    end else begin
      check("dig_at_most_one", 32'($countones(~dig_sel) <= 1), 32'd1);
      if (dig_sel != 6'h3F) begin
        if (run_len == 0) begin
          run_dig    = dig_sel;
          run_seg    = seg;
          run_dp     = dp;
          run_stable = 1'b1;
        end else if (dig_sel != run_dig || seg != run_seg || dp != run_dp) begin
          run_stable = 1'b0;
        end
        run_len++;
      end else if (run_len != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL unexpected_slot observed=%0h expected=none", run_dig);
        end else begin
          exp_e = exp_q.pop_front();
          check("slot_dig", run_dig, exp_e.dig);
          check("slot_seg", run_seg, exp_e.seg);
          check("slot_dp", run_dp, exp_e.dp);
          check("slot_on_cycles", run_len, ON_CYC);
          check("slot_stable", run_stable, 1'b1);
        end
        obs_cnt++;
        run_len = 0;
      end
    end
  end

  initial begin
    int n;
    bit seen;
    checks     = 0;
    fails      = 0;
    obs_cnt    = 0;
    run_len    = 0;
    rstn       = 1'b0;
    time_in    = 20'h00000;
    blank_lead = 1'b0;

    repeat (5) begin
      @(negedge clk_sys);
      check("reset_seg", seg, 7'h7F);
      check("reset_dp", dp, 1'b1);
      check("reset_dig", dig_sel, 6'h3F);
    end

    // First frame after reset shows 00:00:00; 12:34:56 is captured at its end
    push_frame(20'h00000, 1'b0);
    time_in = 20'h49A56;
    #1;
    rstn = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      #1;
      if (dig_sel != 6'h3F) seen = 1'b1;
    end
    check("first_select_cycle", n, BLANK_CYC + 1);
    check("first_select_dig", dig_sel, 6'b111110);
    wait_obs(6);

    do_frame(20'h49A56, 1'b0, 20'h49A56, 1'b0, 20'h0);
    // 12:34:57 driven during slot 2 must wait for the next frame
    do_frame(20'h49A56, 1'b0, 20'h49A56, 1'b1, 20'h49A57);
    do_frame(20'h49A57, 1'b0, 20'h14000, 1'b0, 20'h0);
    do_frame(20'h14000, 1'b1, 20'h14000, 1'b0, 20'h0);
    do_frame(20'h14000, 1'b0, 20'h49A5A, 1'b0, 20'h0);

    // Invalid sec_l shows a dash; then reset in the middle of slot 3
    blank_lead = 1'b0;
    push_frame(20'h49A5A, 1'b0);
    wait_obs(3);
    repeat (4) @(negedge clk_sys);
    #1;
    check("pre_reset_dig3", dig_sel, 6'b110111);
    rstn = 1'b0;
    #1;
    check("mid_reset_seg", seg, 7'h7F);
    check("mid_reset_dp", dp, 1'b1);
    check("mid_reset_dig", dig_sel, 6'h3F);
    exp_q.delete();
    repeat (2) @(negedge clk_sys);
    #1;
    push_frame(20'h00000, 1'b0);
    rstn = 1'b1;
    wait_obs(6);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
